// File: rtl/ecc_sed_pkg.sv
// Shared definitions for the single-error-detect parity code.
// Both the link encoder and the receive-side decoder use these.
package ecc_sed_pkg;
  localparam int DATA_WIDTH = 12;

  typedef logic [DATA_WIDTH:0] sed_codeword_t;

  // Even parity over the payload; the encoder places it in the codeword MSB.
  function automatic logic sed_parity(input logic [DATA_WIDTH-1:0] data);
    return ^data;
  endfunction
endpackage

// File: rtl/ecc_sed_syndrome.sv
// Combinational syndrome for the SED parity code.
// A result of 1 means an odd number of bits in the codeword flipped.
module ecc_sed_syndrome #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] codeword,
  output logic             syndrome
);
  assign syndrome = ^codeword;
endmodule

// File: rtl/ecc_sed_decoder.sv
// SED parity checker with a one-deep registered output stage and error status.
// Words pass through uncorrected; mismatches are flagged, counted and made sticky.
module ecc_sed_decoder #(
  parameter int DATA_WIDTH = ecc_sed_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enc_valid,
  output logic                  enc_ready,
  input  logic [DATA_WIDTH:0]   enc_codeword,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_err,
  input  logic                  err_clr,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  err_count
);
  import ecc_sed_pkg::*;

  logic                 syndrome;
  logic                 acc;
  logic                 rel;
  logic                 err_acc;
  logic                 cnt_full;
  logic [CNT_WIDTH-1:0] cnt_base;

  ecc_sed_syndrome #(.WIDTH(DATA_WIDTH + 1)) u_syndrome (
    .codeword (enc_codeword),
    .syndrome (syndrome)
  );

  // Ready looks at the downstream ready so a full stage drains and refills in one cycle.
  assign enc_ready = !rst && (!data_valid || data_ready);
  assign acc       = enc_valid && enc_ready;
  assign rel       = data_valid && data_ready;
  assign err_acc   = acc && syndrome;

  // A clear is applied before a same-cycle error, so the collision yields a count of 1.
  assign cnt_base  = err_clr ? '0 : err_count;
  assign cnt_full  = &cnt_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid <= 1'b0;
      data       <= '0;
      data_err   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      if (acc) begin
        data_valid <= 1'b1;
        data       <= enc_codeword[DATA_WIDTH-1:0];
        data_err   <= syndrome;
      end else if (rel) begin
        data_valid <= 1'b0;
      end
      err_sticky <= (err_sticky && !err_clr) || err_acc;
      err_count  <= (err_acc && !cnt_full) ? cnt_base + {{(CNT_WIDTH-1){1'b0}}, 1'b1}
                                           : cnt_base;
    end
  end
endmodule
